// File: rtl/furcula_wb_bridge_if.sv
// Furcula request port and pipelined Wishbone master port of the bridge.
// slave = bridge view, master = requester/Wishbone-slave environment view.
interface furcula_wb_bridge_if #(
   parameter int DW = 64,
   parameter int AW = 64
);
   localparam int LB = $clog2(DW / 8);

   logic          f_cyc_i;
   logic          f_stb_i;
   logic          f_we_i;
   logic          f_signed_i;
   logic [1:0]    f_siz_i;
   logic [AW-1:0] f_adr_i;
   logic [DW-1:0] f_dat_i;
   logic          f_ack_o;
   logic          f_err_o;
   logic [DW-1:0] f_dat_o;
   logic          f_busy_o;

   logic             wb_cyc_o;
   logic             wb_stb_o;
   logic             wb_we_o;
   logic [AW-LB-1:0] wb_adr_o;
   logic [DW/8-1:0]  wb_sel_o;
   logic [DW-1:0]    wb_dat_o;
   logic [DW-1:0]    wb_dat_i;
   logic             wb_ack_i;
   logic             wb_err_i;
   logic             wb_stall_i;

   modport slave (
      input  f_cyc_i, f_stb_i, f_we_i, f_signed_i, f_siz_i, f_adr_i, f_dat_i,
      output f_ack_o, f_err_o, f_dat_o, f_busy_o,
      output wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
      input  wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i
   );

   modport master (
      output f_cyc_i, f_stb_i, f_we_i, f_signed_i, f_siz_i, f_adr_i, f_dat_i,
      input  f_ack_o, f_err_o, f_dat_o, f_busy_o,
      input  wb_cyc_o, wb_stb_o, wb_we_o, wb_adr_o, wb_sel_o, wb_dat_o,
      output wb_dat_i, wb_ack_i, wb_err_i, wb_stall_i
   );
endinterface

// File: rtl/furcula_wb_bridge.sv
// Single-outstanding Furcula to pipelined Wishbone bridge: lane steering,
// read extension, alignment check, wait timeout and requester abort.
module furcula_wb_bridge #(
   parameter int DW      = 64,
   parameter int AW      = 64,
   parameter int TIMEOUT = 255
) (
   input logic                 clk_i,
   input logic                 reset_ni,
   furcula_wb_bridge_if.slave  bus
);
   localparam int NUM_LANES = DW / 8;
   localparam int LB        = $clog2(NUM_LANES);
   localparam int CW        = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TO_LAST = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   typedef struct packed {
      logic          we;
      logic          sgn;
      logic [1:0]    siz;
      logic [LB-1:0] off;
   } req_t;

   state_t        state;
   req_t          req;
   logic [CW-1:0] cnt;
   logic          take_rsp;
   logic          timed_out;

   function automatic logic misaligned(input logic [2:0] a, input logic [1:0] siz);
      case (siz)
         2'd0:    misaligned = 1'b0;
         2'd1:    misaligned = a[0];
         2'd2:    misaligned = |a[1:0];
         default: misaligned = (|a) | (DW == 32);
      endcase
   endfunction

   function automatic logic [NUM_LANES-1:0] lane_sel(input logic [LB-1:0] off, input logic [1:0] siz);
      logic [NUM_LANES-1:0] r;
      for (int i = 0; i < NUM_LANES; i++)
         r[i] = (i >= int'(off)) && (i < int'(off) + (1 << siz));
      return r;
   endfunction

   function automatic logic [DW-1:0] lane_rep(input logic [DW-1:0] d, input logic [1:0] siz);
      logic [DW-1:0] r;
      for (int i = 0; i < NUM_LANES; i++)
         r[i*8 +: 8] = d[(i % (1 << siz))*8 +: 8];
      return r;
   endfunction

   // Shift the addressed lanes down to bit 0, then zero- or sign-fill above the top selected bit.
   function automatic logic [DW-1:0] rd_extract(input logic [DW-1:0] d, input req_t r);
      logic [DW-1:0] s;
      logic [DW-1:0] res;
      int            top;
      s   = d >> {r.off, 3'b000};
      top = (8 << r.siz) - 1;
      if (top > DW - 1) top = DW - 1;
      for (int i = 0; i < DW; i++)
         res[i] = (i <= top) ? s[i] : (r.sgn & s[top]);
      return res;
   endfunction

   always_comb begin
      take_rsp  = (bus.wb_ack_i | bus.wb_err_i) & ((state == WAIT) | ~bus.wb_stall_i);
      timed_out = (TIMEOUT > 0) && (cnt == TO_LAST);
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state        <= IDLE;
         req          <= '0;
         cnt          <= '0;
         bus.f_ack_o  <= 1'b0;
         bus.f_err_o  <= 1'b0;
         bus.f_busy_o <= 1'b0;
         bus.f_dat_o  <= '0;
         bus.wb_cyc_o <= 1'b0;
         bus.wb_stb_o <= 1'b0;
         bus.wb_we_o  <= 1'b0;
         bus.wb_adr_o <= '0;
         bus.wb_sel_o <= '0;
         bus.wb_dat_o <= '0;
      end else begin
         bus.f_ack_o <= 1'b0;
         bus.f_err_o <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.f_cyc_i && bus.f_stb_i) begin
                  bus.f_busy_o <= 1'b1;
                  req <= '{we: bus.f_we_i, sgn: bus.f_signed_i, siz: bus.f_siz_i,
                           off: bus.f_adr_i[LB-1:0]};
                  if (misaligned(bus.f_adr_i[2:0], bus.f_siz_i)) begin
                     state       <= RESP;
                     bus.f_err_o <= 1'b1;
                  end else begin
                     state        <= ISSUE;
                     cnt          <= '0;
                     bus.wb_cyc_o <= 1'b1;
                     bus.wb_stb_o <= 1'b1;
                     bus.wb_we_o  <= bus.f_we_i;
                     bus.wb_adr_o <= bus.f_adr_i[AW-1:LB];
                     bus.wb_sel_o <= lane_sel(bus.f_adr_i[LB-1:0], bus.f_siz_i);
                     bus.wb_dat_o <= lane_rep(bus.f_dat_i, bus.f_siz_i);
                  end
               end
            end
            ISSUE, WAIT: begin
               cnt <= cnt + 1'b1;
               // Abort outranks any response; a slave reply in this cycle is dropped.
               if (!bus.f_cyc_i) begin
                  state        <= IDLE;
                  bus.f_busy_o <= 1'b0;
                  bus.wb_cyc_o <= 1'b0;
                  bus.wb_stb_o <= 1'b0;
               end else if (take_rsp) begin
                  state        <= RESP;
                  bus.wb_cyc_o <= 1'b0;
                  bus.wb_stb_o <= 1'b0;
                  if (bus.wb_err_i) begin
                     bus.f_err_o <= 1'b1;
                  end else begin
                     bus.f_ack_o <= 1'b1;
                     if (!req.we) bus.f_dat_o <= rd_extract(bus.wb_dat_i, req);
                  end
               end else if (timed_out) begin
                  state        <= RESP;
                  bus.f_err_o  <= 1'b1;
                  bus.wb_cyc_o <= 1'b0;
                  bus.wb_stb_o <= 1'b0;
               end else if (state == ISSUE && !bus.wb_stall_i) begin
                  state        <= WAIT;
                  bus.wb_stb_o <= 1'b0;
               end
            end
            RESP: begin
               state        <= IDLE;
               bus.f_busy_o <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_furcula_wb_bridge.sv
// Directed bench: DW=64/TIMEOUT=4 and DW=32 bridges, table of single transactions
// plus timeout, abort and asynchronous-reset sequences.
module tb_furcula_wb_bridge;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   always #5 clk = ~clk;

   logic        sel32 = 1'b0;
   logic        f_cyc = 1'b0, f_stb = 1'b0, f_we = 1'b0, f_signed = 1'b0;
   logic [1:0]  f_siz = '0;
   logic [63:0] f_adr = '0, f_dat = '0, wb_dat = '0;
   logic        wb_ack = 1'b0, wb_err = 1'b0, wb_stall = 1'b0;

   furcula_wb_bridge_if #(.DW(64), .AW(64)) if64 ();
   furcula_wb_bridge_if #(.DW(32), .AW(32)) if32 ();

   furcula_wb_bridge #(.DW(64), .AW(64), .TIMEOUT(4)) u64 (.clk_i(clk), .reset_ni(reset_n), .bus(if64.slave));
   furcula_wb_bridge #(.DW(32), .AW(32), .TIMEOUT(255)) u32 (.clk_i(clk), .reset_ni(reset_n), .bus(if32.slave));

   assign if64.f_cyc_i = f_cyc & ~sel32;
   assign if64.f_stb_i = f_stb & ~sel32;
   assign if64.f_we_i = f_we;
   assign if64.f_signed_i = f_signed;
   assign if64.f_siz_i = f_siz;
   assign if64.f_adr_i = f_adr;
   assign if64.f_dat_i = f_dat;
   assign if64.wb_dat_i = wb_dat;
   assign if64.wb_ack_i = wb_ack;
   assign if64.wb_err_i = wb_err;
   assign if64.wb_stall_i = wb_stall;

   assign if32.f_cyc_i = f_cyc & sel32;
   assign if32.f_stb_i = f_stb & sel32;
   assign if32.f_we_i = f_we;
   assign if32.f_signed_i = f_signed;
   assign if32.f_siz_i = f_siz;
   assign if32.f_adr_i = f_adr[31:0];
   assign if32.f_dat_i = f_dat[31:0];
   assign if32.wb_dat_i = wb_dat[31:0];
   assign if32.wb_ack_i = wb_ack;
   assign if32.wb_err_i = wb_err;
   assign if32.wb_stall_i = wb_stall;

   logic        o_cyc, o_stb, o_we, o_ack, o_err, o_busy;
   logic [7:0]  o_sel;
   logic [63:0] o_adr, o_wdat, o_fdat;
   always_comb begin
      o_cyc  = sel32 ? if32.wb_cyc_o : if64.wb_cyc_o;
      o_stb  = sel32 ? if32.wb_stb_o : if64.wb_stb_o;
      o_we   = sel32 ? if32.wb_we_o  : if64.wb_we_o;
      o_ack  = sel32 ? if32.f_ack_o  : if64.f_ack_o;
      o_err  = sel32 ? if32.f_err_o  : if64.f_err_o;
      o_busy = sel32 ? if32.f_busy_o : if64.f_busy_o;
      o_sel  = sel32 ? {4'b0, if32.wb_sel_o} : if64.wb_sel_o;
      o_adr  = sel32 ? {34'b0, if32.wb_adr_o} : {3'b0, if64.wb_adr_o};
      o_wdat = sel32 ? {32'b0, if32.wb_dat_o} : if64.wb_dat_o;
      o_fdat = sel32 ? {32'b0, if32.f_dat_o} : if64.f_dat_o;
   end

   int total = 0, bad = 0;
   logic [63:0] last64 = '0, last32 = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   task automatic rst_chk(input string tag);
      chk({tag, "_ctl64"}, {if64.wb_cyc_o, if64.wb_stb_o, if64.wb_we_o, if64.f_ack_o, if64.f_err_o, if64.f_busy_o}, 0);
      chk({tag, "_bus64"}, {if64.wb_sel_o, 64'(if64.wb_adr_o)} | if64.wb_dat_o, 0);
      chk({tag, "_fdat64"}, if64.f_dat_o, 0);
      chk({tag, "_ctl32"}, {if32.wb_cyc_o, if32.wb_stb_o, if32.wb_we_o, if32.f_ack_o, if32.f_err_o, if32.f_busy_o}, 0);
      chk({tag, "_bus32"}, {if32.wb_sel_o, if32.wb_adr_o, if32.wb_dat_o}, 0);
      chk({tag, "_fdat32"}, 64'(if32.f_dat_o), 0);
   endtask

   typedef struct {
      bit          u32;
      bit          we;
      bit          sgn;
      bit [1:0]    siz;
      logic [63:0] adr, wdat, rdat;
      int          stall;
      int          resp;      // 0 ack, 1 err, 2 ack+err
      bit          mis;
      logic [7:0]  sel;
      logic [63:0] wadr, wwdat, rexp;
   } vec_t;

   function automatic vec_t mk(bit u, bit we, bit sg, bit [1:0] sz, logic [63:0] a, logic [63:0] wd,
                               logic [63:0] rd, int st, int rs, bit m, logic [7:0] sl,
                               logic [63:0] wa, logic [63:0] ww, logic [63:0] re);
      vec_t v;
      v.u32 = u; v.we = we; v.sgn = sg; v.siz = sz; v.adr = a; v.wdat = wd; v.rdat = rd;
      v.stall = st; v.resp = rs; v.mis = m; v.sel = sl; v.wadr = wa; v.wwdat = ww; v.rexp = re;
      return v;
   endfunction

   task automatic drive_req(input bit we, input bit sg, input bit [1:0] sz, input logic [63:0] a,
                            input logic [63:0] wd, input logic [63:0] rd);
      f_we = we; f_signed = sg; f_siz = sz; f_adr = a; f_dat = wd; wb_dat = rd;
      f_cyc = 1'b1; f_stb = 1'b1;
   endtask

   task automatic run(input vec_t v);
      int stb_n;
      logic [63:0] last;
      sel32 = v.u32;
      last = v.u32 ? last32 : last64;
      wb_stall = (v.stall > 0); wb_ack = 1'b0; wb_err = 1'b0;
      drive_req(v.we, v.sgn, v.siz, v.adr, v.wdat, v.rdat);
      @(negedge clk);
      f_stb = 1'b0;
      if (v.mis) begin
         chk("mis_cyc", o_cyc, 0);
         chk("mis_err", o_err, 1);
         chk("mis_ack", o_ack, 0);
         chk("mis_busy", o_busy, 1);
         f_cyc = 1'b0;
         @(negedge clk);
         chk("mis_err_clr", o_err, 0);
         chk("mis_cyc2", o_cyc, 0);
         chk("mis_fdat_hold", o_fdat, last);
      end else begin
         chk("cyc", o_cyc, 1);
         chk("we", o_we, v.we);
         chk("sel", o_sel, v.sel);
         chk("adr", o_adr, v.wadr);
         chk("wdat", o_wdat, v.wwdat);
         stb_n = o_stb ? 1 : 0;
         for (int k = 0; k < v.stall; k++) begin
            @(negedge clk);
            if (o_stb) stb_n++;
            chk("stable_sel", o_sel, v.sel);
            chk("stable_wdat", o_wdat, v.wwdat);
         end
         wb_stall = 1'b0;
         wb_ack = (v.resp != 1);
         wb_err = (v.resp != 0);
         @(negedge clk);
         wb_ack = 1'b0; wb_err = 1'b0; f_cyc = 1'b0;
         chk("stb_cycles", stb_n, v.stall + 1);
         chk("cyc_drop", o_cyc, 0);
         chk("ack", o_ack, v.resp == 0);
         chk("err", o_err, v.resp != 0);
         if (v.resp == 0 && !v.we) last = v.rexp;
         chk("fdat", o_fdat, last);
         @(negedge clk);
         chk("resp_pulse", {o_ack, o_err}, 0);
         chk("busy_clr", o_busy, 0);
      end
      if (v.u32) last32 = last; else last64 = last;
   endtask

   vec_t vecs[16];
   int   n_cyc;

   initial begin
      vecs[0]  = mk(0,0,1,0, 64'h1000_0000_0000_0005, 0, 64'h0000_8000_0000_0000, 0,0,0, 8'h20, 64'h0200_0000_0000_0000, 0, 64'hFFFF_FFFF_FFFF_FF80);
      vecs[1]  = mk(0,0,0,0, 64'h1000_0000_0000_0005, 0, 64'h0000_8000_0000_0000, 0,0,0, 8'h20, 64'h0200_0000_0000_0000, 0, 64'h80);
      vecs[2]  = mk(0,1,0,1, 64'hA, 64'hFFFF_FFFF_FFFF_ABCD, 0, 1,0,0, 8'h0C, 64'h1, 64'hABCD_ABCD_ABCD_ABCD, 0);
      vecs[3]  = mk(0,0,1,2, 64'h4, 0, 64'h8765_4321_0000_0000, 0,0,0, 8'hF0, 0, 0, 64'hFFFF_FFFF_8765_4321);
      vecs[4]  = mk(0,0,0,1, 64'h6, 0, 64'hF00D_0000_0000_0000, 2,0,0, 8'hC0, 0, 0, 64'hF00D);
      vecs[5]  = mk(0,0,1,1, 64'h2, 0, 64'h0000_0000_7FFF_0000, 0,0,0, 8'h0C, 0, 0, 64'h7FFF);
      vecs[6]  = mk(0,0,1,3, 64'h8, 0, 64'h0123_4567_89AB_CDEF, 0,0,0, 8'hFF, 64'h1, 0, 64'h0123_4567_89AB_CDEF);
      vecs[7]  = mk(0,1,0,3, 64'h10, 64'hDEAD_BEEF_CAFE_F00D, 0, 0,0,0, 8'hFF, 64'h2, 64'hDEAD_BEEF_CAFE_F00D, 0);
      vecs[8]  = mk(0,0,0,2, 64'h2, 0, 0, 0,0,1, 0, 0, 0, 0);
      vecs[9]  = mk(0,1,0,1, 64'h3, 0, 0, 0,0,1, 0, 0, 0, 0);
      vecs[10] = mk(0,0,1,0, 64'h1, 64'h55, 64'hFFFF_FFFF_FFFF_FFFF, 0,2,0, 8'h02, 0, 64'h5555_5555_5555_5555, 0);
      vecs[11] = mk(0,0,0,0, 64'h7, 64'hAA, 64'h1, 0,1,0, 8'h80, 0, 64'hAAAA_AAAA_AAAA_AAAA, 0);
      vecs[12] = mk(1,1,0,1, 64'h6, 64'h1234, 0, 2,0,0, 8'h0C, 64'h1, 64'h1234_1234, 0);
      vecs[13] = mk(1,0,0,3, 64'h0, 0, 0, 0,0,1, 0, 0, 0, 0);
      vecs[14] = mk(1,0,1,0, 64'h3, 0, 64'hFE00_0000, 0,0,0, 8'h08, 0, 0, 64'hFFFF_FFFE);
      vecs[15] = mk(1,0,1,2, 64'h4, 0, 64'h89AB_CDEF, 1,0,0, 8'h0F, 64'h1, 0, 64'h89AB_CDEF);

      repeat (2) @(negedge clk);
      rst_chk("reset");
      reset_n = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 16; i++) run(vecs[i]);

      // No slave response: cycle must be cut after TIMEOUT=4 cycles with an error.
      sel32 = 1'b0;
      drive_req(0, 0, 2'd0, 64'h0, 0, 0);
      @(negedge clk);
      f_stb = 1'b0;
      n_cyc = 0;
      for (int k = 0; k < 20; k++) begin
         if (o_err || o_ack) break;
         if (o_cyc) n_cyc++;
         @(negedge clk);
      end
      chk("to_cycles", n_cyc, 4);
      chk("to_err", o_err, 1);
      chk("to_ack", o_ack, 0);
      chk("to_cyc_drop", o_cyc, 0);
      f_cyc = 1'b0;
      @(negedge clk);
      chk("to_err_clr", o_err, 0);

      // Requester drops f_cyc in WAIT; a late slave reply must be ignored.
      drive_req(0, 0, 2'd0, 64'h0, 0, 64'hFF);
      @(negedge clk);
      f_stb = 1'b0;
      @(negedge clk);
      chk("abort_wait", {o_cyc, o_stb}, 2'b10);
      f_cyc = 1'b0;
      @(negedge clk);
      chk("abort_cyc", o_cyc, 0);
      chk("abort_resp", {o_ack, o_err, o_busy}, 0);
      wb_ack = 1'b1; wb_err = 1'b1;
      @(negedge clk);
      chk("late_resp", {o_ack, o_err, o_busy, o_cyc}, 0);
      chk("late_fdat", o_fdat, last64);
      wb_ack = 1'b0; wb_err = 1'b0;

      // New request, then reset asserted mid-ISSUE.
      drive_req(1, 0, 2'd3, 64'h18, 64'h1111_2222_3333_4444, 0);
      @(negedge clk);
      f_stb = 1'b0;
      chk("issue2_cyc", o_cyc, 1);
      #2 reset_n = 1'b0;
      #1 rst_chk("arst");
      f_cyc = 1'b0;
      @(negedge clk);
      chk("arst_resp", {o_ack, o_err, o_cyc}, 0);

      // Request presented as reset releases is taken on the very first edge.
      drive_req(0, 1, 2'd0, 64'h5, 0, 64'h0000_8000_0000_0000);
      reset_n = 1'b1;
      @(negedge clk);
      f_stb = 1'b0;
      chk("first_accept", o_cyc, 1);
      wb_ack = 1'b1;
      @(negedge clk);
      wb_ack = 1'b0; f_cyc = 1'b0;
      chk("first_ack", o_ack, 1);
      chk("first_fdat", o_fdat, 64'hFFFF_FFFF_FFFF_FF80);
      @(negedge clk);
      chk("first_idle", {o_ack, o_busy}, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
